// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator sequencer: walks two operands MSB-first through
// one external 1-bit equality cell and stops at the first differing bit.
module serial_compare_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cmp_x,
    output logic             cmp_y,
    input  logic             cmp_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    nbits
);

    localparam int            IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic [CW-1:0] NB_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic [CW-1:0]    r_nbits;
    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_accept;
    logic             w_last;

    assign w_bit_a  = r_a[r_idx];
    assign w_bit_b  = r_b[r_idx];
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Comparator inputs are driven only while scanning so the cell idles at x=y=0.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cmp_x     = 1'b0;
        cmp_y     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                cmp_x = w_bit_a;
                cmp_y = w_bit_b;
                if (!cmp_z || w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_nbits <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IDX_TOP;
            r_cnt <= '0;
        end else if (r_state == SCAN) begin
            if (!cmp_z) begin
                // First differing bit decides the order: A has the 1 => A is larger.
                r_eq    <= 1'b0;
                r_gt    <= w_bit_a;
                r_lt    <= ~w_bit_a;
                r_nbits <= r_cnt + CW'(1);
            end else if (w_last) begin
                r_eq    <= 1'b1;
                r_gt    <= 1'b0;
                r_lt    <= 1'b0;
                r_nbits <= NB_FULL;
            end else begin
                r_idx <= r_idx - IW'(1);
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign eq    = r_eq;
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign nbits = r_nbits;

endmodule
